execute_cc_stage: RTL

//  Y86-64 execute stage: sits directly downstream of decode/writeback and consumes icode/ifun, rA/rB and valA/valB/valC.

---
 rtl/execute_cc_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/execute_cc_stage.sv
// rtl/execute_cc_stage.sv - Y86-64 execute stage: ALU, condition codes, Cnd and a registered handshake output
module execute_cc_stage #(
    parameter int         W          = 64,
    parameter int         STACK_STEP = 8,
    parameter logic [2:0] CC_RESET   = 3'b100
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [3:0]   icode_i,
    input  logic [3:0]   ifun_i,
    input  logic [3:0]   rA_i,
    input  logic [3:0]   rB_i,
    input  logic [W-1:0] valA_i,
    input  logic [W-1:0] valB_i,
    input  logic [W-1:0] valC_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [3:0]   icode_o,
    output logic [3:0]   rA_o,
    output logic [3:0]   rB_o,
    output logic [W-1:0] valA_o,
    output logic [W-1:0] valE_o,
    output logic         Cnd_o,
    output logic [2:0]   cc_o,
    output logic [1:0]   stat_o,
    output logic         halted_o
);
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_INS = 2'd2;

    localparam logic [W-1:0] STEP = W'(STACK_STEP);

    logic [W-1:0] sum_c, diff_c, alu_e;
    logic         zf, sf, of;
    logic         cond_c, cnd_c, of_c, cc_we;
    logic [1:0]   stat_c;
    logic         accept;

    assign zf = cc_o[2];
    assign sf = cc_o[1];
    assign of = cc_o[0];

    assign in_ready_o = !halted_o && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    assign sum_c  = valB_i + valA_i;
    assign diff_c = valB_i - valA_i;

    // Condition is evaluated against the flags currently held, before any same-edge update.
    always_comb begin
        cond_c = 1'b0;
        case (ifun_i)
            4'd0: cond_c = 1'b1;
            4'd1: cond_c = (sf ^ of) | zf;
            4'd2: cond_c = sf ^ of;
            4'd3: cond_c = zf;
            4'd4: cond_c = !zf;
            4'd5: cond_c = !(sf ^ of);
            4'd6: cond_c = !(sf ^ of) && !zf;
            default: cond_c = 1'b0;
        endcase
    end

    always_comb begin
        alu_e  = '0;
        cnd_c  = 1'b1;
        stat_c = STAT_AOK;
        of_c   = 1'b0;
        cc_we  = 1'b0;
        case (icode_i)
            IHALT: stat_c = STAT_HLT;
            INOP: ;
            ICMOVXX, IJXX: begin
                if (icode_i == ICMOVXX) alu_e = valA_i;
                cnd_c = cond_c;
                if (ifun_i > 4'd6) stat_c = STAT_INS;
            end
            IIRMOVQ:          alu_e = valC_i;
            IRMMOVQ, IMRMOVQ: alu_e = valB_i + valC_i;
            IOPQ: begin
                cc_we = 1'b1;
                case (ifun_i)
                    4'd0: begin
                        alu_e = sum_c;
                        of_c  = (valA_i[W-1] == valB_i[W-1]) && (sum_c[W-1] != valA_i[W-1]);
                    end
                    4'd1: begin
                        alu_e = diff_c;
                        of_c  = (valA_i[W-1] != valB_i[W-1]) && (diff_c[W-1] != valB_i[W-1]);
                    end
                    4'd2: alu_e = valB_i & valA_i;
                    4'd3: alu_e = valB_i ^ valA_i;
                    default: begin
                        stat_c = STAT_INS;
                        cc_we  = 1'b0;
                    end
                endcase
            end
            ICALL, IPUSHQ: alu_e = valB_i - STEP;
            IRET, IPOPQ:   alu_e = valB_i + STEP;
            default:       stat_c = STAT_INS;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            icode_o     <= INOP;
            rA_o        <= RNONE;
            rB_o        <= RNONE;
            valA_o      <= '0;
            valE_o      <= '0;
            Cnd_o       <= 1'b0;
            cc_o        <= CC_RESET;
            stat_o      <= STAT_AOK;
            halted_o    <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            icode_o     <= icode_i;
            rA_o        <= rA_i;
            rB_o        <= rB_i;
            valA_o      <= valA_i;
            valE_o      <= alu_e;
            Cnd_o       <= cnd_c;
            stat_o      <= stat_c;
            if (cc_we) cc_o <= {alu_e == '0, alu_e[W-1], of_c};
            if (icode_i == IHALT) halted_o <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
endmodule
